// File: rtl/cpu_execute_mc.sv
// Execute stage: combinational ALU into 3a, plus an iterative shift-add multiplier that stalls decode.
// Define EXEC_MUL_EN to build the multiplier and BUSY state; otherwise MUL_OP is a single-cycle ALU op.
module alu #(
  parameter int         WIDTH   = 32,
  parameter logic [4:0] MUL_OP  = 5'h18,
  parameter bit         HAS_MUL = 1'b1
) (
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             cond
);
  always_comb begin
    y = '0;
    case (op)
      5'h00:   y = a + b;
      5'h01:   y = a - b;
      5'h02:   y = a & b;
      5'h03:   y = a | b;
      5'h04:   y = a ^ b;
      5'h05:   y = a << b;
      5'h06:   y = a >> b;
      5'h07:   y = b;
      default: y = (HAS_MUL && op == MUL_OP) ? a * b : '0;
    endcase
    cond = (y == '0);
  end
endmodule

module cpu_execute_mc #(
  parameter int         WIDTH      = 32,
  parameter int         INSN_WIDTH = 48,
  parameter int         ST_WIDTH   = 35,
  parameter int         POP_WIDTH  = 11,
  parameter logic [4:0] MUL_OP     = 5'h18
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  valid_2a,
  output logic                  stall_2a,
  input  logic                  kill_4a,
  input  logic [4:0]            alu__op_2a,
  input  logic [1:0]            c__alu_left_2a,
  input  logic [1:0]            c__alu_right_2a,
  input  logic [1:0]            c__branch_2a,
  input  logic [1:0]            c__to_push_2a,
  input  logic [INSN_WIDTH-1:0] instruction_2a,
  input  logic [31:0]           pc_2a,
  input  logic [ST_WIDTH-1:0]   st__top_0_2a,
  input  logic [ST_WIDTH-1:0]   st__top_1_2a,
  input  logic [POP_WIDTH-1:0]  st__to_pop_2a,
  output logic                  valid_3a,
  output logic [WIDTH-1:0]      alu__out_3a,
  output logic                  alu__cond_3a,
  output logic [1:0]            c__branch_3a,
  output logic [1:0]            c__to_push_3a,
  output logic [INSN_WIDTH-1:0] instruction_3a,
  output logic [31:0]           pc_3a,
  output logic [POP_WIDTH-1:0]  st__to_pop_3a
);
  localparam logic [1:0] UC_RIGHT_IMM  = 2'b00;
  localparam logic [1:0] UC_RIGHT_STK0 = 2'b01;
  localparam logic [1:0] UC_RIGHT_STK1 = 2'b10;

  logic [WIDTH-1:0] left, right, alu_y;
  logic             alu_cond, accept;

  // Stack entries carry tag bits above the operand that this stage ignores.
  logic unused_st_hi;
  assign unused_st_hi = ^{st__top_0_2a, st__top_1_2a};

  always_comb begin
    left = '0;
    case (c__alu_left_2a)
      UC_RIGHT_IMM:  left = instruction_2a[WIDTH-1:0];
      UC_RIGHT_STK0: left = st__top_0_2a[WIDTH-1:0];
      UC_RIGHT_STK1: left = st__top_1_2a[WIDTH-1:0];
      default:       left = '0;
    endcase
    right = '0;
    case (c__alu_right_2a)
      UC_RIGHT_IMM:  right = instruction_2a[WIDTH-1:0];
      UC_RIGHT_STK0: right = st__top_0_2a[WIDTH-1:0];
      UC_RIGHT_STK1: right = st__top_1_2a[WIDTH-1:0];
      default:       right = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam bit ALU_MUL = 1'b0;
`else
  localparam bit ALU_MUL = 1'b1;
`endif

  alu #(.WIDTH(WIDTH), .MUL_OP(MUL_OP), .HAS_MUL(ALU_MUL)) u_alu (
    .op(alu__op_2a), .a(left), .b(right), .y(alu_y), .cond(alu_cond)
  );

  assign accept = valid_2a & ~stall_2a & ~kill_4a;

`ifdef EXEC_MUL_EN
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q;
  logic [WIDTH-1:0]      mcand_q, mplier_q, acc_q, acc_nxt;
  logic [CW-1:0]         cnt_q;
  logic [1:0]            br_q, push_q;
  logic [INSN_WIDTH-1:0] insn_q;
  logic [31:0]           pc_q;
  logic [POP_WIDTH-1:0]  pop_q;

  assign stall_2a = (state_q == BUSY);
  assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      mcand_q <= '0; mplier_q <= '0; acc_q <= '0; cnt_q <= '0;
      br_q <= '0; push_q <= '0; insn_q <= '0; pc_q <= '0; pop_q <= '0;
      valid_3a <= 1'b0; alu__out_3a <= '0; alu__cond_3a <= 1'b0;
      c__branch_3a <= '0; c__to_push_3a <= '0; instruction_3a <= '0;
      pc_3a <= '0; st__to_pop_3a <= '0;
    end else begin
      valid_3a <= 1'b0;
      if (kill_4a) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (accept) begin
            if (alu__op_2a == MUL_OP) begin
              mcand_q  <= left;
              mplier_q <= right;
              acc_q    <= '0;
              cnt_q    <= CW'(WIDTH - 1);
              br_q     <= c__branch_2a;
              push_q   <= c__to_push_2a;
              insn_q   <= instruction_2a;
              pc_q     <= pc_2a;
              pop_q    <= st__to_pop_2a;
              state_q  <= BUSY;
            end else begin
              alu__out_3a    <= alu_y;
              alu__cond_3a   <= alu_cond;
              c__branch_3a   <= c__branch_2a;
              c__to_push_3a  <= c__to_push_2a;
              instruction_3a <= instruction_2a;
              pc_3a          <= pc_2a;
              st__to_pop_3a  <= st__to_pop_2a;
              valid_3a       <= 1'b1;
            end
          end
          BUSY: begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              alu__out_3a    <= acc_nxt;
              alu__cond_3a   <= (acc_nxt == '0);
              c__branch_3a   <= br_q;
              c__to_push_3a  <= push_q;
              instruction_3a <= insn_q;
              pc_3a          <= pc_q;
              st__to_pop_3a  <= pop_q;
              valid_3a       <= 1'b1;
              state_q        <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
`else
  assign stall_2a = 1'b0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_3a <= 1'b0; alu__out_3a <= '0; alu__cond_3a <= 1'b0;
      c__branch_3a <= '0; c__to_push_3a <= '0; instruction_3a <= '0;
      pc_3a <= '0; st__to_pop_3a <= '0;
    end else begin
      valid_3a <= accept;
      if (accept) begin
        alu__out_3a    <= alu_y;
        alu__cond_3a   <= alu_cond;
        c__branch_3a   <= c__branch_2a;
        c__to_push_3a  <= c__to_push_2a;
        instruction_3a <= instruction_2a;
        pc_3a          <= pc_2a;
        st__to_pop_3a  <= st__to_pop_2a;
      end
    end
  end
`endif
endmodule

// File: doc/cpu_execute_mc.md
# cpu_execute_mc

Parametrised execute stage with a multi-cycle multiply path, a valid/stall handshake and kill-driven flush. It sits between decode (stage 2a) and memory/writeback (stage 3a). Single-cycle ops go through the combinational `alu` instance and register into 3a. `MUL_OP` runs an iterative shift-add multiplier that back-pressures decode until its result is registered.

## Interface
Parameters:
- `WIDTH`, 32, datapath and ALU operand width (≥ 2).
- `INSN_WIDTH`, 48, instruction word width; immediate is `instruction_2a[WIDTH-1:0]`.
- `ST_WIDTH`, 35, stack-entry width; operand is `[WIDTH-1:0]`.
- `POP_WIDTH`, 11, width of `st__to_pop`.
- `MUL_OP`, 5'h18, `alu__op_2a` code that selects the multiplier.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_b` in 1: asynchronous active-low reset.
- `valid_2a` in 1: 2a holds a live instruction.
- `stall_2a` out 1: decode must hold all 2a inputs this cycle.
- `kill_4a` in 1: flush; discard in-flight and incoming work.
- `alu__op_2a` in 5: ALU operation.
- `c__alu_left_2a`, `c__alu_right_2a` in 2: operand selects.
- `c__branch_2a`, `c__to_push_2a` in 2: pass-through controls.
- `instruction_2a` in INSN_WIDTH; `pc_2a` in 32; `st__top_0_2a`, `st__top_1_2a` in ST_WIDTH; `st__to_pop_2a` in POP_WIDTH.
- `valid_3a` out 1: 3a fields hold a new result this cycle.
- `alu__out_3a` out WIDTH; `alu__cond_3a` out 1.
- `c__branch_3a`, `c__to_push_3a` out 2; `instruction_3a` out INSN_WIDTH; `pc_3a` out 32; `st__to_pop_3a` out POP_WIDTH.

## Operation
Operand select, each side independently:
- `UC_RIGHT_IMM` selects the immediate.
- `UC_RIGHT_STK0` selects stack top 0.
- `UC_RIGHT_STK1` selects stack top 1.
- Any other encoding selects zero. Never X.

Accept = `valid_2a & !stall_2a & !kill_4a`.

FSM has two states, IDLE and BUSY; `stall_2a = (state == BUSY)`.
- IDLE, accept, op ≠ `MUL_OP`:
  - Register ALU result and cond, plus all pass-through fields, into 3a.
  - `valid_3a <= 1`.
- IDLE, accept, op = `MUL_OP`:
  - Capture operands and pass-through fields internally.
  - Clear accumulator; counter <= WIDTH-1.
  - `valid_3a <= 0`; go to BUSY.
- IDLE, no accept: `valid_3a <= 0`; 3a data fields hold their values.
- BUSY, each cycle:
  - If the multiplier LSB is 1, add the shifted multiplicand to the accumulator.
  - Shift the multiplicand left and the multiplier right; decrement the counter.
- BUSY, counter = 0:
  - 3a <= final product plus captured fields.
  - `alu__cond_3a` <= (product == 0).
  - `valid_3a <= 1`; go to IDLE.
- Product is unsigned, truncated to WIDTH bits (modulo 2^WIDTH).
- `kill_4a` in any state:
  - Next state is IDLE; `valid_3a <= 0`.
  - Accumulator contents are discarded; 3a data fields hold.
  - Kill overrides accept and completion in the same cycle.

## Timing
- Single-cycle op accepted in cycle N: result in 3a in cycle N+1.
- MUL accepted in cycle N:
  - `stall_2a` high in cycles N+1..N+WIDTH.
  - Result valid in cycle N+WIDTH+1, with `stall_2a` low in that cycle.
  - A new instruction can be accepted in cycle N+WIDTH+1.
- Back-to-back single-cycle ops: one per cycle.
- Kill in cycle K: `stall_2a` low in cycle K+1.
- Reset (asynchronous, effective immediately):
  - State IDLE, `stall_2a` 0.
  - All 3a outputs 0, including `valid_3a`.
  - Reset mid-BUSY abandons the multiply.
- While stalled, 2a inputs are ignored; decode guarantees they are stable.

## Configuration
- `EXEC_MUL_EN` defined: iterative multiplier and BUSY state are built in, as described above.
- `EXEC_MUL_EN` undefined:
  - No multiplier and no BUSY state; `stall_2a` is tied to 0.
  - `MUL_OP` is handed to `alu` like any other op, with single-cycle latency.

## Test plan
- Assert `rst_b` low mid-multiply -> all 3a outputs 0 and `stall_2a` 0 immediately; after release, an add accepted in cycle N gives `valid_3a` in N+1.
- Add, left IMM 5, right STK0 7 -> `alu__out_3a` = 12 and `valid_3a` = 1 next cycle; pc and instruction passed through unchanged.
- Operand select 2'b11 on both sides with add -> `alu__out_3a` = 0.
- MUL, 6 × 7, `pc_2a` 0x100 -> `stall_2a` high for exactly 32 cycles; `alu__out_3a` = 42, `pc_3a` = 0x100 and `alu__cond_3a` = 0 in cycle N+33.
- MUL, 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000001; MUL 0x10000 × 0x10000 -> 0 with `alu__cond_3a` = 1.
- `kill_4a` pulsed in BUSY cycle 10 -> no `valid_3a` from the killed MUL; `stall_2a` 0 next cycle; a following add is accepted and completes normally.
- Without `EXEC_MUL_EN`: random op stream -> `stall_2a` never asserts and every accept yields `valid_3a` one cycle later.
